// File: rtl/sram_stream_pkg.sv
// rtl/sram_stream_pkg.sv - shared state encoding and sizing for the SRAM stream reader
package sram_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Reads on the SRAM port plus words held for the consumer never exceed this.
   localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/sram_rd_skid_fifo.sv
// rtl/sram_rd_skid_fifo.sv - two-entry read-data FIFO with fall-through when empty
module sram_rd_skid_fifo
   import sram_stream_pkg::*;
#(
   parameter int SRAM_W = 128
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_flush,
   input  logic              i_push,
   input  logic [SRAM_W-1:0] i_data,
   input  logic              i_pop,
   output logic [SRAM_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [1:0]        o_count
);

   logic [SRAM_W-1:0] mem_q [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;
   logic              wr_en, rd_en;

   // A word arriving into an empty FIFO is visible at once; if it is popped
   // in that same cycle it never touches storage.
   always_comb begin
      wr_en    = i_push && !(i_pop && (count_q == 2'd0)) && !i_flush;
      rd_en    = i_pop && (count_q != 2'd0);
      wr_ptr_d = wr_ptr_q ^ wr_en;
      rd_ptr_d = rd_ptr_q ^ rd_en;
      count_d  = count_q + {1'b0, wr_en} - {1'b0, rd_en};
      if (i_flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   assign o_data  = (count_q == 2'd0) ? i_data : mem_q[rd_ptr_q];
   assign o_empty = (count_q == 2'd0) && !i_push;
   assign o_full  = (count_q == 2'(FIFO_DEPTH));
   assign o_count = count_q;

endmodule

// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - streams a block of SRAM words to a ready/valid consumer
module sram_stream_reader
   import sram_stream_pkg::*;
#(
   parameter int ADR_W  = 10,
   parameter int SRAM_W = 128,
   parameter int CNT_W  = 11
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_start,
   input  logic              i_clear,
   input  logic [ADR_W-1:0]  i_base_addr,
   input  logic [CNT_W-1:0]  i_count,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADR_W-1:0]  o_sram_addr,
   output logic              o_sram_rden,
   input  logic [SRAM_W-1:0] i_sram_data,
   output logic              o_valid,
   output logic [SRAM_W-1:0] o_data,
   input  logic              i_ready
);

   state_e           state_q, state_d;
   logic [ADR_W-1:0] addr_q, addr_d;
   logic             rden_q, rden_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] rd_left_q, rd_left_d;
   logic [CNT_W-1:0] beat_left_q, beat_left_d;
   logic             done_q, done_d;

   logic             fifo_empty, fifo_full;
   logic [1:0]       fifo_count;
   logic             pop;
   logic [2:0]       occ_sum;
   logic             credit_ok;

   assign pop = o_valid && i_ready;

   // Words held, word on the data bus and read on the address port together
   // must leave room for one more once this cycle's pop is accounted for.
   assign occ_sum   = {1'b0, fifo_count} + {2'b0, pend_q} + {2'b0, rden_q};
   assign credit_ok = !fifo_full && (occ_sum < (3'(FIFO_DEPTH) + {2'b0, pop}));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rden_d      = 1'b0;
      pend_d      = rden_q;
      rd_left_d   = rd_left_q;
      beat_left_d = beat_left_q;
      done_d      = 1'b0;
      if (pop) begin
         beat_left_d = beat_left_q - 1'b1;
      end
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               if (i_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = ST_RUN;
                  rden_d      = 1'b1;
                  addr_d      = i_base_addr;
                  rd_left_d   = i_count - 1'b1;
                  beat_left_d = i_count;
               end
            end
         end
         ST_RUN: begin
            if (rd_left_q == '0) begin
               state_d = ST_DRAIN;
            end else if (credit_ok) begin
               rden_d    = 1'b1;
               addr_d    = addr_q + 1'b1;
               rd_left_d = rd_left_q - 1'b1;
               if (rd_left_q == CNT_W'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && (beat_left_q == CNT_W'(1))) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (i_clear) begin
         state_d     = ST_IDLE;
         rden_d      = 1'b0;
         pend_d      = 1'b0;
         rd_left_d   = '0;
         beat_left_d = '0;
         done_d      = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rden_q      <= 1'b0;
         pend_q      <= 1'b0;
         rd_left_q   <= '0;
         beat_left_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rden_q      <= rden_d;
         pend_q      <= pend_d;
         rd_left_q   <= rd_left_d;
         beat_left_q <= beat_left_d;
         done_q      <= done_d;
      end
   end

   sram_rd_skid_fifo #(
      .SRAM_W (SRAM_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_flush (i_clear),
      .i_push  (pend_q),
      .i_data  (i_sram_data),
      .i_pop   (pop),
      .o_data  (o_data),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_count)
   );

   assign o_valid     = !fifo_empty;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_done      = done_q;
   assign o_sram_addr = addr_q;
   assign o_sram_rden = rden_q;

endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - directed self-checking bench for sram_stream_reader
module tb_sram_stream_reader;

   localparam int ADR_W  = 10;
   localparam int SRAM_W = 128;
   localparam int CNT_W  = 11;

   logic              clk   = 1'b0;
   logic              rstn  = 1'b1;
   logic              start = 1'b0;
   logic              clear = 1'b0;
   logic              ready = 1'b0;
   logic [ADR_W-1:0]  base  = '0;
   logic [CNT_W-1:0]  count = '0;
   logic [SRAM_W-1:0] sram_data = '0;
   logic              busy, done, rden, valid;
   logic [ADR_W-1:0]  addr;
   logic [SRAM_W-1:0] data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_stream_reader #(
      .ADR_W  (ADR_W),
      .SRAM_W (SRAM_W),
      .CNT_W  (CNT_W)
   ) dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_start     (start),
      .i_clear     (clear),
      .i_base_addr (base),
      .i_count     (count),
      .o_busy      (busy),
      .o_done      (done),
      .o_sram_addr (addr),
      .o_sram_rden (rden),
      .i_sram_data (sram_data),
      .o_valid     (valid),
      .o_data      (data),
      .i_ready     (ready)
   );

   function automatic logic [SRAM_W-1:0] pat(input logic [ADR_W-1:0] a);
      logic [31:0] w;
      w = {22'd0, a};
      return {32'hDEAD_0000 | w, 32'hBEEF_0000 | w, ~w, w ^ 32'h0000_5A5A};
   endfunction

   // SRAM model: data valid exactly one cycle after the read enable.
   always @(posedge clk) begin
      if (rden) sram_data <= pat(addr);
   end

   task automatic chk(input string tag, input logic [SRAM_W-1:0] obs, input logic [SRAM_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input string tag, input logic [ADR_W-1:0] b, input int n,
                       input bit toggle, input int clr_at);
      int issued, beats, last_cyc, done_cyc, done_pulses, first_valid, last_rd, max_out, quiet_bad;
      logic [SRAM_W-1:0] held;
      bit stalled, aborted;
      issued = 0; beats = 0; last_cyc = -1; done_cyc = -1; done_pulses = 0;
      first_valid = -1; last_rd = -1; max_out = 0; quiet_bad = 0;
      held = '0; stalled = 1'b0; aborted = 1'b0;
      base = b; count = CNT_W'(n); start = 1'b1; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         if (cyc == 1) chk({tag, " busy_c1"}, busy, (n != 0));
         if (done) begin
            done_pulses++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (rden) begin
            chk({tag, " rd_addr"}, addr, ADR_W'(b + issued));
            issued++;
            last_rd = cyc;
         end
         if (issued - beats > max_out) max_out = issued - beats;
         if (stalled) begin
            chk({tag, " hold_valid"}, valid, 1'b1);
            chk({tag, " hold_data"}, data, held);
         end
         ready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (clr_at != 0 && beats == clr_at - 1 && valid) begin
            clear = 1'b1;
            ready = 1'b0;
            aborted = 1'b1;
         end
         if (valid && first_valid < 0) first_valid = cyc;
         stalled = valid && !ready;
         held = data;
         if (valid && ready) begin
            chk({tag, " beat"}, data, pat(ADR_W'(b + beats)));
            beats++;
            last_cyc = cyc;
         end
         @(negedge clk);
         if (aborted) break;
         if (done_cyc >= 0 && cyc >= done_cyc + 1) break;
      end
      if (aborted) begin
         clear = 1'b0;
         chk({tag, " clr_busy"}, busy, 1'b0);
         chk({tag, " clr_valid"}, valid, 1'b0);
         for (int k = 0; k < 4; k++) begin
            if (done || valid || rden) quiet_bad++;
            @(negedge clk);
         end
         chk({tag, " clr_quiet"}, quiet_bad, 0);
         chk({tag, " clr_no_done"}, done_pulses, 0);
         chk({tag, " clr_beats"}, beats, clr_at - 1);
      end else begin
         chk({tag, " n_beats"}, beats, n);
         chk({tag, " n_reads"}, issued, n);
         chk({tag, " done_cycle"}, done_cyc, (n == 0) ? 1 : last_cyc + 1);
         chk({tag, " done_pulses"}, done_pulses, 1);
         chk({tag, " outstanding_le2"}, (max_out <= 2), 1'b1);
         chk({tag, " busy_end"}, busy, 1'b0);
         if (!toggle && n != 0) begin
            chk({tag, " first_valid"}, first_valid, 2);
            chk({tag, " last_read"}, last_rd, n);
         end
      end
   endtask

   initial begin
      #2 rstn = 1'b0;
      #1;
      chk("rst busy", busy, 1'b0);
      chk("rst done", done, 1'b0);
      chk("rst rden", rden, 1'b0);
      chk("rst valid", valid, 1'b0);
      chk("rst addr", addr, '0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      xfer("basic", 10'h010, 4, 1'b0, 0);
      xfer("wrap", 10'h3FE, 4, 1'b0, 0);
      xfer("toggle", 10'h040, 8, 1'b1, 0);
      xfer("zero", 10'h123, 0, 1'b0, 0);
      xfer("clear", 10'h020, 6, 1'b0, 3);
      xfer("after_clr", 10'h100, 3, 1'b0, 0);

      base = 10'h200; count = CNT_W'(8); start = 1'b1; ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("midrst busy", busy, 1'b0);
      chk("midrst done", done, 1'b0);
      chk("midrst rden", rden, 1'b0);
      chk("midrst valid", valid, 1'b0);
      chk("midrst addr", addr, '0);
      @(negedge clk);
      chk("midrst valid2", valid, 1'b0);
      rstn = 1'b1;
      @(negedge clk);
      xfer("post_rst", 10'h155, 5, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_stream_reader.md
SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

Interface
REQ-001 Parameter ADR_W, default 10, SHALL set the accelerator-side SRAM word-address width.
REQ-002 Parameter SRAM_W, default 128, SHALL set the SRAM and stream data width.
REQ-003 Parameter CNT_W, default 11, SHALL set the transfer-length width.
REQ-004 i_clk  in  1  SHALL be the single clock; all logic rising-edge.
REQ-005 i_rstn  in  1  SHALL be the asynchronous active-low reset.
REQ-006 i_start  in  1  SHALL be the one-cycle start pulse, sampled only in IDLE.
REQ-007 i_clear  in  1  SHALL be a synchronous abort that returns the block to IDLE.
REQ-008 i_base_addr  in  ADR_W  SHALL give the first word address, captured on accepted start.
REQ-009 i_count  in  CNT_W  SHALL give the number of words to read, captured on accepted start.
REQ-010 o_busy  out  1  SHALL be high in RUN and DRAIN.
REQ-011 o_done  out  1  SHALL be a one-cycle pulse on transfer completion.
REQ-012 o_sram_addr  out  ADR_W  SHALL drive the SRAM accelerator-side address.
REQ-013 o_sram_rden  out  1  SHALL drive the SRAM accelerator-side read enable.
REQ-014 i_sram_data  in  SRAM_W  SHALL carry read data, valid exactly one cycle after o_sram_rden.
REQ-015 o_valid / o_data  out  1 / SRAM_W  SHALL form the output stream.
REQ-016 i_ready  in  1  SHALL be the stream consumer ready; a beat transfers when o_valid && i_ready.

Function
REQ-017 The FSM SHALL use states IDLE, RUN and DRAIN.
- IDLE->RUN on i_start with i_count!=0.
- RUN->DRAIN when the last read issues.
- DRAIN->IDLE when the last beat transfers.
REQ-018 i_start with i_count==0 SHALL stay in IDLE, issue no reads, and pulse o_done the next cycle.
REQ-019 In RUN, a read SHALL issue (o_sram_rden=1) only when fifo_occupancy + inflight < 2.
REQ-020 Each issued read SHALL increment o_sram_addr by 1, wrapping modulo 2^ADR_W.
REQ-021 o_sram_rden and o_sram_addr SHALL be registered outputs.
REQ-022 Read data SHALL be written into a 2-entry FIFO one cycle after issue; no data is ever dropped.
REQ-023 o_valid SHALL equal FIFO not-empty, and o_data SHALL be the FIFO head.
REQ-024 Simultaneous FIFO push and pop SHALL keep occupancy constant.
REQ-025 With i_ready held high, the block SHALL sustain one beat per cycle after 2 cycles of start-up latency (first o_valid two cycles after i_start).
REQ-026 Once o_valid rises, o_data SHALL be held stable until the beat transfers.
REQ-027 o_done SHALL pulse in the cycle after the count-th beat transfers.
REQ-028 i_start while o_busy SHALL be ignored.
REQ-029 i_clear SHALL, on the next edge:
- go to IDLE;
- flush the FIFO;
- drop any in-flight read data;
- not pulse o_done.
i_clear has priority over i_start.

Reset
REQ-030 Asserting i_rstn low SHALL, asynchronously, force:
- state=IDLE;
- o_busy=0, o_done=0, o_sram_rden=0, o_valid=0;
- o_sram_addr=0;
- FIFO empty, inflight=0, counters=0.
o_data is don't-care while o_valid=0.
REQ-031 Reset mid-transfer SHALL discard all pending reads and beats.

Structure
REQ-032 The state enum (IDLE/RUN/DRAIN) SHALL live in shared package sram_stream_pkg.
REQ-033 The 2-entry FIFO SHALL be sub-module sram_rd_skid_fifo, parameterised by SRAM_W, with push/pop/full/empty ports.

Verification
REQ-034 Base 0x010, count 4, i_ready=1 -> reads at 0x010..0x013 on consecutive cycles; 4 beats in order; o_done one cycle after the 4th beat.
REQ-035 Base 0x3FE, count 4, ADR_W=10 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-036 Count 8 with i_ready toggling 1010... -> never more than 2 outstanding (FIFO + inflight); all 8 beats delivered in order; o_data stable while stalled.
REQ-037 Count 0 -> o_sram_rden never asserts; o_done pulses the cycle after i_start; o_busy stays 0.
REQ-038 i_clear at beat 3 of 6 -> IDLE next cycle; o_valid=0; no o_done; a new start at base 0x100 streams correct data.
REQ-039 i_rstn low mid-transfer, then a new start -> all outputs at reset values during reset; the fresh transfer completes correctly.
